led_pattern_to_value: RTL

LED_PATTERN_TO_VALUE -- requirements
Module: led_pattern_to_value

---
 rtl/led_pattern_to_value.sv | 116 +++++++++++
 1 files changed

// File: rtl/led_pattern_to_value.sv
// Seven-segment scanner decoder: debounces per-digit strobed patterns into four nibbles and pulses when a full frame is seen.
// Latency: one clock from the accepting strobe to value_out/err_mask; frame_valid one clock after the last digit lands.
// Backpressure: none; strobes are consumed every cycle. Optional blank-digit decode via SEG_BLANK_ACCEPT_EN.
module led_pattern_to_value #(
    parameter int STABLE_CNT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [1:0]  digit_sel,
    input  logic        seg_strobe,
    output logic [15:0] value_out,
    output logic [3:0]  err_mask,
    output logic        frame_valid
);

    typedef enum logic {COLLECT, EMIT} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    state_t      state_q, state_d;
    logic [6:0]  last_pat_q [4];
    logic [6:0]  last_pat_d [4];
    logic [3:0]  cnt_q [4];
    logic [3:0]  cnt_d [4];
    logic [15:0] value_q, value_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  acc_q, acc_d;
    logic        accept;
    logic [4:0]  dec;
    logic [3:0]  cnt_inc;

    // Returns {error, nibble}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = {1'b0, 4'h0};
            7'b0110000: r = {1'b0, 4'h1};
            7'b1101101: r = {1'b0, 4'h2};
            7'b1111001: r = {1'b0, 4'h3};
            7'b0110011: r = {1'b0, 4'h4};
            7'b1011011: r = {1'b0, 4'h5};
            7'b1011111: r = {1'b0, 4'h6};
            7'b1110010: r = {1'b0, 4'h7};
            7'b1111111: r = {1'b0, 4'h8};
            7'b1111011: r = {1'b0, 4'h9};
`ifdef SEG_BLANK_ACCEPT_EN
            7'b0000000: r = {1'b0, 4'hF};
`endif
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        last_pat_d = last_pat_q;
        cnt_d      = cnt_q;
        value_d    = value_q;
        err_d      = err_q;
        acc_d      = (state_q == EMIT) ? 4'b0000 : acc_q;
        accept     = 1'b0;
        dec        = decode(seg_in);
        cnt_inc    = cnt_q[digit_sel] + 4'd1;

        case (state_q)
            COLLECT: if (acc_q == 4'b1111) state_d = EMIT;
            EMIT:    state_d = COLLECT;
            default: state_d = COLLECT;
        endcase

        if (seg_strobe) begin
            if (seg_in == last_pat_q[digit_sel]) begin
                // cnt never exceeds STABLE, so the increment cannot wrap.
                if (cnt_q[digit_sel] != STABLE) begin
                    cnt_d[digit_sel] = cnt_inc;
                    accept           = (cnt_inc == STABLE);
                end
            end else begin
                last_pat_d[digit_sel] = seg_in;
                cnt_d[digit_sel]      = 4'd1;
                accept                = (STABLE == 4'd1);
            end
            if (accept) begin
                value_d[{digit_sel, 2'b00} +: 4] = dec[3:0];
                err_d[digit_sel]                 = dec[4];
                acc_d[digit_sel]                 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            value_q <= 16'h0000;
            err_q   <= 4'b0000;
            acc_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                last_pat_q[i] <= 7'b0000000;
                cnt_q[i]      <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            value_q    <= value_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
            last_pat_q <= last_pat_d;
            cnt_q      <= cnt_d;
        end
    end

    assign value_out   = value_q;
    assign err_mask    = err_q;
    assign frame_valid = (state_q == EMIT);

endmodule
